// File: rtl/pair_printer_pkg.sv
// Shared definitions for the pair line printer.
//   state_t     : line-printing FSM states
//   ASCII_*     : fixed characters emitted around each line
//   arrow_char  : character at a given position of the " -> " separator
package pair_printer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LHS   = 3'd1,
    ARROW = 3'd2,
    RHS   = 3'd3,
    CR    = 3'd4,
    LF    = 3'd5
  } state_t;

  localparam logic [7:0] ASCII_SP   = 8'h20;
  localparam logic [7:0] ASCII_DASH = 8'h2D;
  localparam logic [7:0] ASCII_GT   = 8'h3E;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  // Separator is " -> ", indexed 0..3.
  function automatic logic [7:0] arrow_char(input logic [1:0] idx);
    logic [7:0] c;
    c = ASCII_SP;
    case (idx)
      2'd0:    c = ASCII_SP;
      2'd1:    c = ASCII_DASH;
      2'd2:    c = ASCII_GT;
      default: c = ASCII_SP;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte transmitter.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin a frame with data; only honoured while idle = 1
//   data[7:0]  : byte to send, LSB first
//   tx         : serial line, idles high, forced high by reset
//   idle       : transmitter can take a new byte on this clock edge
//
// idle is also high in the final cycle of a stop bit, so a byte offered
// then starts its start bit exactly as the previous stop bit ends; this
// is what makes back-to-back bytes gapless.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       idle
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LOAD = BW'(CLKS_PER_BIT - 1);

  logic          active_q, active_d;
  logic [BW-1:0] baud_q,   baud_d;
  logic [3:0]    bit_q,    bit_d;
  logic [7:0]    shift_q,  shift_d;
  logic          tx_q,     tx_d;

  // bit_q counts down the remaining bit slots: 9 = start, 8..1 = data,
  // 0 = stop. baud_q counts down the cycles left in the current slot.
  assign idle = !active_q || ((bit_q == 4'd0) && (baud_q == '0));
  assign tx   = tx_q;

  always_comb begin
    active_d = active_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    if (start && idle) begin
      active_d = 1'b1;
      baud_d   = BAUD_LOAD;
      bit_d    = 4'd9;
      shift_d  = data;
      tx_d     = 1'b0;
    end else if (active_q) begin
      if (baud_q == '0) begin
        if (bit_q == 4'd0) begin
          active_d = 1'b0;
          tx_d     = 1'b1;
        end else begin
          bit_d  = bit_q - 4'd1;
          baud_d = BAUD_LOAD;
          if (bit_q == 4'd1) begin
            tx_d = 1'b1;
          end else begin
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end
      end else begin
        baud_d = baud_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      baud_q   <= '0;
      bit_q    <= 4'd0;
      shift_q  <= 8'h00;
      tx_q     <= 1'b1;
    end else begin
      active_q <= active_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
    end
  end

endmodule

// File: rtl/pair_line_printer.sv
// Prints each transform line "<lhs chars> -> <rhs chars>\r\n" over UART.
//   clk, rst_n          : clock, asynchronous active-low reset
//   pair_valid/ready    : handshake for one (lhs, rhs, pair_last) pair
//   lhs, rhs            : input-side and transformed characters
//   pair_last           : pair closes the current line
//   tx                  : 8N1 serial output
//   busy                : line in progress or byte in flight
//   overflow            : sticky, a line reached DEPTH pairs without last
//
// LHS characters go out as they are accepted; RHS characters wait in a
// DEPTH-entry buffer until the separator has been sent.
//
// state | meaning (byte currently in flight)
// IDLE  | nothing; waiting for the first pair of a line
// LHS   | an lhs character; may accept the next pair when it completes
// ARROW | separator character arrow_idx of " -> "
// RHS   | buffer entry rd_ptr-1
// CR    | carriage return
// LF    | line feed; line ends when it completes
//
// Every state hands the transmitter its next byte in the same cycle the
// current byte finishes, so a line has no idle bits between bytes.
module pair_line_printer
  import pair_printer_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH        = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pair_valid,
  output logic       pair_ready,
  input  logic [7:0] lhs,
  input  logic [7:0] rhs,
  input  logic       pair_last,
  output logic       tx,
  output logic       busy,
  output logic       overflow
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST_SLOT = PW'(DEPTH - 1);

  state_t        state_q,     state_d;
  logic [PW-1:0] wr_ptr_q,    wr_ptr_d;
  logic [PW-1:0] rd_ptr_q,    rd_ptr_d;
  logic [1:0]    arrow_idx_q, arrow_idx_d;
  logic          close_q,     close_d;
  logic          overflow_q,  overflow_d;
  logic          ready_en_q,  ready_en_d;
  logic [7:0]    buf_q [DEPTH];
  logic [7:0]    buf_d [DEPTH];

  logic       uart_start;
  logic [7:0] uart_data;
  logic       uart_idle;
  logic       accept;
  logic       at_last_slot;

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk   (clk),
    .rst_n (rst_n),
    .start (uart_start),
    .data  (uart_data),
    .tx    (tx),
    .idle  (uart_idle)
  );

  // ready_en_q keeps pair_ready low throughout reset and lets it rise on
  // the first edge after release. A closed line refuses further pairs.
  assign pair_ready   = ready_en_q && uart_idle &&
                        ((state_q == IDLE) || ((state_q == LHS) && !close_q));
  assign accept       = pair_valid && pair_ready;
  assign at_last_slot = (wr_ptr_q == LAST_SLOT);
  assign busy         = (state_q != IDLE) || !uart_idle;
  assign overflow     = overflow_q;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    arrow_idx_d = arrow_idx_q;
    close_d     = close_q;
    overflow_d  = overflow_q;
    ready_en_d  = 1'b1;
    buf_d       = buf_q;
    uart_start  = 1'b0;
    uart_data   = 8'h00;

    if (accept) begin
      uart_start                = 1'b1;
      uart_data                 = lhs;
      buf_d[wr_ptr_q[AW-1:0]]   = rhs;
      wr_ptr_d                  = wr_ptr_q + 1'b1;
      state_d                   = LHS;
      if (pair_last || at_last_slot) begin
        close_d = 1'b1;
      end
      if (at_last_slot && !pair_last) begin
        overflow_d = 1'b1;
      end
    end else begin
      case (state_q)
        LHS: begin
          if (close_q && uart_idle) begin
            uart_start  = 1'b1;
            uart_data   = arrow_char(2'd0);
            arrow_idx_d = 2'd0;
            state_d     = ARROW;
          end
        end
        ARROW: begin
          if (uart_idle) begin
            uart_start = 1'b1;
            if (arrow_idx_q == 2'd3) begin
              // A closed line always holds at least one pair.
              uart_data = buf_q[0];
              rd_ptr_d  = PW'(1);
              state_d   = RHS;
            end else begin
              uart_data   = arrow_char(arrow_idx_q + 2'd1);
              arrow_idx_d = arrow_idx_q + 2'd1;
            end
          end
        end
        RHS: begin
          if (uart_idle) begin
            uart_start = 1'b1;
            if (rd_ptr_q == wr_ptr_q) begin
              uart_data = ASCII_CR;
              state_d   = CR;
            end else begin
              uart_data = buf_q[rd_ptr_q[AW-1:0]];
              rd_ptr_d  = rd_ptr_q + 1'b1;
            end
          end
        end
        CR: begin
          if (uart_idle) begin
            uart_start = 1'b1;
            uart_data  = ASCII_LF;
            state_d    = LF;
          end
        end
        LF: begin
          if (uart_idle) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            close_d  = 1'b0;
            state_d  = IDLE;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      arrow_idx_q <= 2'd0;
      close_q     <= 1'b0;
      overflow_q  <= 1'b0;
      ready_en_q  <= 1'b0;
      buf_q       <= '{default: 8'h00};
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      arrow_idx_q <= arrow_idx_d;
      close_q     <= close_d;
      overflow_q  <= overflow_d;
      ready_en_q  <= ready_en_d;
      buf_q       <= buf_d;
    end
  end

endmodule

// File: tb/tb_pair_line_printer.sv
// Directed bench for pair_line_printer: decodes tx with a UART receiver
// model and compares the bytes, line durations and flags against
// hand-written expectations.
module tb_pair_line_printer;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk;
  logic       rst_n;
  logic       pair_valid;
  logic       pair_ready;
  logic [7:0] lhs;
  logic [7:0] rhs;
  logic       pair_last;
  logic       tx;
  logic       busy;
  logic       overflow;

  int n_total;
  int n_bad;
  int cyc;
  int acc;
  int framing_err;
  logic [7:0] rxq [$];
  int         stq [$];

  pair_line_printer #(
    .CLKS_PER_BIT(CPB),
    .DEPTH       (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pair_valid (pair_valid),
    .pair_ready (pair_ready),
    .lhs        (lhs),
    .rhs        (rhs),
    .pair_last  (pair_last),
    .tx         (tx),
    .busy       (busy),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && pair_valid && pair_ready) acc <= acc + 1;
  end

  // UART receiver: samples mid-bit, records each frame's start cycle.
  initial begin
    logic [7:0] b;
    int t0;
    forever begin
      @(negedge clk);
      if (rst_n && tx == 1'b0) begin
        t0 = cyc;
        b  = 8'h00;
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        if (tx != 1'b1) framing_err = framing_err + 1;
        rxq.push_back(b);
        stq.push_back(t0);
      end
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_total = n_total + 1;
    if (got != exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Call at a negedge; returns at the negedge after the accepting edge.
  task automatic send_pair(input logic [7:0] l, input logic [7:0] r, input logic last);
    int n;
    lhs        = l;
    rhs        = r;
    pair_last  = last;
    pair_valid = 1'b1;
    n = 0;
    while (!pair_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      chk("ready_timeout", 0, 1);
      pair_valid = 1'b0;
    end else begin
      @(negedge clk);
    end
  endtask

  // Expects s followed by CR LF; dur > 0 also checks first start bit to
  // end of the LF stop bit.
  task automatic expect_line(input string tag, input string s, input int dur);
    int n;
    int k;
    logic [7:0] e;
    n = s.len() + 2;
    k = 0;
    while (rxq.size() < n && k < 20000) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_count"}, (rxq.size() >= n) ? 1 : 0, 1);
    if (rxq.size() < n) return;
    for (int i = 0; i < n; i++) begin
      if (i < s.len()) e = s[i];
      else if (i == s.len()) e = 8'h0D;
      else e = 8'h0A;
      chk($sformatf("%s_b%0d", tag, i), int'(rxq[i]), int'(e));
    end
    if (dur > 0) chk({tag, "_dur"}, stq[n-1] - stq[0] + 10 * CPB, dur);
    for (int i = 0; i < n; i++) begin
      void'(rxq.pop_front());
      void'(stq.pop_front());
    end
  endtask

  task automatic expect_idle(input string tag);
    repeat (4) @(negedge clk);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0;
    int lows;
    int n;
    logic lvl;
    n_total = 0; n_bad = 0; cyc = 0; acc = 0; framing_err = 0;
    rst_n = 1'b0; pair_valid = 1'b0; lhs = 8'h00; rhs = 8'h00; pair_last = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx", int'(tx), 1);
    chk("rst_ready", int'(pair_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ovf", int'(overflow), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", int'(pair_ready), 1);

    // Single pair: 8 bytes, 320 cycles
    send_pair("a", "b", 1'b1);
    pair_valid = 1'b0;
    expect_line("single", "a -> b", 320);
    chk("single_ovf", int'(overflow), 0);
    expect_idle("single");

    // Two pairs held valid: one accept per lhs byte, gapless line
    acc0 = acc;
    send_pair("1", "1", 1'b0);
    send_pair("1", " ", 1'b1);
    pair_valid = 1'b0;
    chk("two_accepts", acc - acc0, 2);
    expect_line("two", "11 -> 1 ", 400);
    expect_idle("two");

    // Bit timing of 0x55: alternating levels, each exactly CPB cycles
    send_pair(8'h55, "z", 1'b1);
    pair_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      lvl = (i % 2 == 1);
      chk($sformatf("bit%0d_lvl", i), int'(tx), int'(lvl));
      n = 0;
      while (tx == lvl && n < 64) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("bit%0d_len", i), n, CPB);
    end
    expect_line("b55", "U -> z", 320);
    expect_idle("b55");

    // Overflow at DEPTH pairs without last
    send_pair("a", "A", 1'b0);
    send_pair("b", "B", 1'b0);
    send_pair("c", "C", 1'b0);
    chk("ovf_before", int'(overflow), 0);
    send_pair("d", "D", 1'b0);
    chk("ovf_set", int'(overflow), 1);
    send_pair("e", "E", 1'b0);
    send_pair("f", "F", 1'b1);
    pair_valid = 1'b0;
    expect_line("ovf1", "abcd -> ABCD", 560);
    expect_line("ovf2", "ef -> EF", 400);
    chk("ovf_sticky", int'(overflow), 1);
    expect_idle("ovf");

    // Backpressure gap between pairs of one line
    send_pair("p", "P", 1'b0);
    pair_valid = 1'b0;
    repeat (40) @(negedge clk);
    lows = 0;
    for (int i = 0; i < 50; i++) begin
      if (tx == 1'b0) lows++;
      @(negedge clk);
    end
    chk("gap_tx_low", lows, 0);
    chk("gap_busy", int'(busy), 1);
    send_pair("q", "Q", 1'b1);
    pair_valid = 1'b0;
    expect_line("gap", "pq -> PQ", 0);
    expect_idle("gap");

    // Reset during an rhs data bit
    send_pair("m", "n", 1'b1);
    pair_valid = 1'b0;
    repeat (210) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", int'(tx), 1);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_ovf", int'(overflow), 0);
    chk("mid_rst_ready", int'(pair_ready), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rel_ready", int'(pair_ready), 1);
    repeat (60) @(negedge clk);
    rxq.delete();
    stq.delete();
    send_pair("x", "y", 1'b1);
    pair_valid = 1'b0;
    expect_line("post_rst", "x -> y", 320);
    repeat (60) @(negedge clk);
    chk("post_rst_extra", rxq.size(), 0);
    chk("framing", framing_err, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
